// File: rtl/nearest_pkg.sv
// Shared types and helpers for the nearest_tracker streaming selector.
package nearest_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // All-ones value of a width+1 bit distance, used as the "no candidate yet" distance
  function automatic int unsigned dist_max(input int unsigned width);
    return (32'd1 << (width + 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/nearest_tracker_abs_diff.sv
// Combinational |a-b| in WIDTH+1 bits; NEAREST_TRACKER_SIGNED_EN selects two's complement operands.
module abs_diff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   dist_c
);

  localparam int unsigned DW = WIDTH + 1;

  logic [DW-1:0] ax;
  logic [DW-1:0] bx;
  logic [DW-1:0] diff;

`ifdef NEAREST_TRACKER_SIGNED_EN
  assign ax = {a[WIDTH-1], a};
  assign bx = {b[WIDTH-1], b};
`else
  assign ax = {1'b0, a};
  assign bx = {1'b0, b};
`endif

  // Difference always fits in DW signed bits, so the negation never overflows
  assign diff   = ax - bx;
  assign dist_c = diff[DW-1] ? (~diff + DW'(1)) : diff;

endmodule

// File: rtl/nearest_tracker.sv
// Streaming nearest-sample tracker: frame of len samples, reports value/index/distance closest to refI.
// Optional build macro: NEAREST_TRACKER_SIGNED_EN (two's complement samples and reference).
module nearest_tracker
  import nearest_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] refI,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] resultIdx,
  output logic [WIDTH:0]   resultDist,
  output logic             busy
);

  localparam int unsigned   DW   = WIDTH + 1;
  localparam logic [DW-1:0] DMAX = DW'(dist_max(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    bdist_q, bdist_d;
  logic [DW-1:0]    dist_c;

  abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
    .a      (dataIn),
    .b      (ref_q),
    .dist_c (dist_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    idx_d   = idx_q;
    bdist_d = bdist_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ref_d   = refI;
          len_d   = len;
          cnt_d   = '0;
          best_d  = '0;
          idx_d   = '0;
          bdist_d = DMAX;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid && in_ready) begin
          // Strict compare keeps the earliest sample on ties
          if (dist_c < bdist_q) begin
            best_d  = dataIn;
            idx_d   = cnt_q;
            bdist_d = dist_c;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ref_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      bdist_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      bdist_q   <= bdist_d;
      in_ready  <= (state_d == RUN);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign result     = best_q;
  assign resultIdx  = idx_q;
  assign resultDist = bdist_q;

endmodule

// File: tb/tb_nearest_tracker.sv
// Directed and model-checked bench for nearest_tracker (WIDTH=8, CNT_W=8).
module tb_nearest_tracker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] refI;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dataIn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] resultIdx;
  logic [8:0] resultDist;
  logic       busy;

  int checks = 0;
  int errors = 0;

  nearest_tracker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .refI       (refI),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dataIn     (dataIn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .resultIdx  (resultIdx),
    .resultDist (resultDist),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] r, input logic [7:0] l);
    start = 1'b1;
    refI  = r;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Offer one sample until accepted (in_ready sampled before the edge)
  task automatic send(input logic [7:0] s, output bit ok);
    int  n;
    bit  acc;
    n        = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    dataIn   = s;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    ok       = acc;
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic int mdist(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
`ifdef NEAREST_TRACKER_SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(b));
`else
    x = int'(a);
    y = int'(b);
`endif
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; refI = '0; len = '0;
    in_valid = 1'b0; dataIn = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, busy, result, resultIdx, resultDist} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {in_ready, out_valid, busy, result, resultIdx, resultDist});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    do_start(8'd15, 8'd2);
    send(8'd46, ok1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_mid_frame got ov=%b busy=%b exp ov=0 busy=1", out_valid, busy);
    end
    send(8'd14, ok2);
    // out_valid must already be high in the cycle after the last accept
    checks++;
    if (!(ok1 && ok2) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got ok=%b ov=%b ir=%b exp ok=1 ov=1 ir=0", ok1 && ok2, out_valid, in_ready);
    end
    checks++;
    if ({result, resultIdx, resultDist} !== {8'd14, 8'd1, 9'd1}) begin
      errors++;
      $display("FAIL basic_result got %0d/%0d/%0d exp 14/1/1", result, resultIdx, resultDist);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got ov=%b busy=%b exp 0/0", out_valid, busy);
    end
  endtask

  task automatic test_tie();
    bit ok1, ok2, ok3, okw;
    do_start(8'd15, 8'd3);
    send(8'd14, ok1);
    send(8'd16, ok2);
    send(8'd200, ok3);
    wait_out(okw);
    checks++;
    if (!(ok1 && ok2 && ok3 && okw) || {result, resultIdx, resultDist} !== {8'd14, 8'd0, 9'd1}) begin
      errors++;
      $display("FAIL tie_result got %0d/%0d/%0d exp 14/0/1", result, resultIdx, resultDist);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, ok3, okw;
    logic [7:0] s [3];
    s = '{8'd100, 8'd20, 8'd10};
    do_start(8'd15, 8'd3);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      send(s[i], ok1);
      if (i == 0) ok2 = ok1;
      if (i == 1) ok3 = ok1;
    end
    wait_out(okw);
    checks++;
    if (!(ok1 && ok2 && ok3 && okw)) begin
      errors++;
      $display("FAIL bp_handshake got accepted=%b exp 1", ok1 && ok2 && ok3 && okw);
    end
    // Hold off the consumer while poking start and in_valid; nothing may move
    for (int c = 0; c < 5; c++) begin
      start    = (c == 2);
      refI     = 8'd0;
      len      = 8'd0;
      in_valid = $urandom_range(0, 1) != 0;
      dataIn   = 8'd15;
      tick();
      checks++;
      if ({out_valid, in_ready, busy, result, resultIdx, resultDist} !== {1'b1, 1'b0, 1'b1, 8'd20, 8'd1, 9'd5}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got ov=%b ir=%b %0d/%0d/%0d exp ov=1 ir=0 20/1/5",
                 c, out_valid, in_ready, result, resultIdx, resultDist);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    take_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ov=%b busy=%b ir=%b exp 0/0/0", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_zero_len();
    do_start(8'd15, 8'd0);
    checks++;
    if ({out_valid, in_ready, result, resultIdx, resultDist} !== {1'b1, 1'b0, 8'd0, 8'd0, 9'h1FF}) begin
      errors++;
      $display("FAIL zero_len got ov=%b ir=%b %0d/%0d/%h exp ov=1 ir=0 0/0/1ff",
               out_valid, in_ready, result, resultIdx, resultDist);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    bit ok1, okw;
    do_start(8'd40, 8'd1);
    send(8'd41, ok1);
    // Start coinciding with the result handshake must be dropped
    start = 1'b1; refI = 8'd0; len = 8'd1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (!ok1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_ignored got busy=%b ov=%b ir=%b exp 0/0/0", busy, out_valid, in_ready);
    end
    do_start(8'd100, 8'd1);
    send(8'd90, ok1);
    wait_out(okw);
    checks++;
    if (!(ok1 && okw) || {result, resultIdx, resultDist} !== {8'd90, 8'd0, 9'd10}) begin
      errors++;
      $display("FAIL b2b_next_frame got %0d/%0d/%0d exp 90/0/10", result, resultIdx, resultDist);
    end
    take_result();
  endtask

  task automatic test_reset_mid_frame();
    bit ok1, ok2, okw;
    do_start(8'd50, 8'd5);
    send(8'd51, ok1);
    send(8'd60, ok2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result, resultIdx, resultDist} !== 28'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 0", {in_ready, out_valid, busy, result, resultIdx, resultDist});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (!(ok1 && ok2) || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle got busy=%b ov=%b exp 0/0", busy, out_valid);
    end
    do_start(8'd0, 8'd1);
    send(8'd7, ok1);
    wait_out(okw);
    checks++;
    if (!(ok1 && okw) || {result, resultIdx, resultDist} !== {8'd7, 8'd0, 9'd7}) begin
      errors++;
      $display("FAIL rst_mid_next got %0d/%0d/%0d exp 7/0/7", result, resultIdx, resultDist);
    end
    take_result();
  endtask

  task automatic test_signedness();
    bit ok1, ok2, okw;
    logic [24:0] exp_v;
`ifdef NEAREST_TRACKER_SIGNED_EN
    exp_v = {8'h01, 8'd1, 9'd3};
`else
    exp_v = {8'h7F, 8'd0, 9'd127};
`endif
    do_start(8'hFE, 8'd2);
    send(8'h7F, ok1);
    send(8'h01, ok2);
    wait_out(okw);
    checks++;
    if (!(ok1 && ok2 && okw) || {result, resultIdx, resultDist} !== exp_v) begin
      errors++;
      $display("FAIL signedness got %h/%0d/%0d exp %h", result, resultIdx, resultDist, exp_v);
    end
    take_result();
  endtask

  task automatic test_random_frames();
    bit ok, okw, all_ok;
    logic [7:0] r, s, l, eb, ei;
    int ed, d;
    for (int f = 0; f < 20; f++) begin
      r  = 8'($urandom);
      l  = 8'($urandom_range(1, 6));
      eb = 8'd0; ei = 8'd0; ed = 512;
      all_ok = 1'b1;
      do_start(r, l);
      for (int i = 0; i < int'(l); i++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        s = 8'($urandom_range(0, 3) == 0 ? int'(r) + 1 : int'($urandom));
        d = mdist(s, r);
        if (d < ed) begin
          ed = d; eb = s; ei = 8'(i);
        end
        send(s, ok);
        all_ok = all_ok && ok;
      end
      wait_out(okw);
      checks++;
      if (!(all_ok && okw) || {result, resultIdx, resultDist} !== {eb, ei, 9'(ed)}) begin
        errors++;
        $display("FAIL random_frame %0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                 f, result, resultIdx, resultDist, eb, ei, ed);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_frame();
    test_signedness();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
